serial_full_adder: RTL and testbench

// Bit-serial N-bit adder built around a one-bit full-adder cell with a registered carry.

---
 rtl/serial_full_adder.sv | 129 ++++++++++++
 tb/tb_serial_full_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused LSB-first with a registered carry,
// producing a registered sum/carry-out and a one-cycle done pulse after WIDTH clocks.
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_s;
  logic             carry_s;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Next-state logic: operand load, one full-adder step per RUN cycle, result commit
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    bit_s   = fa_sum(a_q[0], b_q[0], carry_q);
    carry_s = fa_carry(a_q[0], b_q[0], carry_q);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = carry_s;
        // The last bit lands at the MSB, so the completed word is res_d itself
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = res_d;
          cout_d  = carry_s;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder at WIDTH=8 and WIDTH=16: vector table,
// multi-cycle corner sequences and random adds, all results checked through scoreboards.
module tb_serial_full_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, cin8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic [8:0]  last8;
  int total = 0;
  int bad = 0;
  int ndone8 = 0;
  int nstart8 = 0;
  int ndone16 = 0;
  int nstart16 = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;
  vec_t vt[8];

  always #5 clk = ~clk;

  serial_full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_full_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: every done pops the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done8) begin
      ndone8++;
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_unexpected: got done with sum %0h, expected no done", sum8);
      end else begin
        chk("result8", {55'd0, cout8, sum8}, {55'd0, q8.pop_front()});
      end
    end
    if (rst_n && done16) begin
      ndone16++;
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done16_unexpected: got done with sum %0h, expected no done", sum16);
      end else begin
        chk("result16", {47'd0, cout16, sum16}, {47'd0, q16.pop_front()});
      end
    end
  end

  // Called at a negedge; the following posedge is the accepting edge
  task automatic start8_t(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [8:0] exp, input bit push);
    a8 = a;
    b8 = b;
    cin8 = c;
    start8 = 1'b1;
    if (push) begin
      q8.push_back(exp);
      nstart8++;
    end
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    cin8 = 1'($urandom);
  endtask

  task automatic wait_done8(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (!done8 && cyc < 200) begin
      if (busy8) bcnt++;
      @(negedge clk);
      cyc++;
    end
    if (!done8) begin
      total++;
      bad++;
      $display("FAIL done8_timeout: got no done after %0d cycles, expected done", cyc);
    end
  endtask

  initial begin
    int cyc, bcnt;
    logic [7:0]  ra, rb;
    logic [15:0] wa, wb;
    logic        rc;

    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vt[5] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    vt[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vt[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
    last8 = 9'h000;
    repeat (3) @(negedge clk);
    chk("rst_outputs8", {52'd0, busy8, done8, cout8, sum8}, 64'd0);
    chk("rst_outputs16", {44'd0, busy16, done16, cout16, sum16}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: latency, busy length, done pulse width, result via scoreboard
    for (int i = 0; i < 8; i++) begin
      start8_t(vt[i].a, vt[i].b, vt[i].cin, {vt[i].co, vt[i].s}, 1'b1);
      chk("busy_after_start", {63'd0, busy8}, 64'd1);
      wait_done8(cyc, bcnt);
      chk("latency", 64'(cyc), 64'd8);
      chk("busy_cycles", 64'(bcnt), 64'd8);
      chk("busy_at_done", {63'd0, busy8}, 64'd0);
      last8 = {vt[i].co, vt[i].s};
      @(negedge clk);
      chk("done_pulse_width", {62'd0, done8, busy8}, 64'd0);
    end

    // Start pulse during RUN is ignored; outputs hold the previous result meanwhile
    start8_t(8'h12, 8'h34, 1'b0, 9'h046, 1'b1);
    repeat (2) @(negedge clk);
    chk("hold_during_run", {55'd0, cout8, sum8}, {55'd0, last8});
    start8_t(8'hAA, 8'h55, 1'b0, 9'h0FF, 1'b0);
    chk("busy_after_ignored", {63'd0, busy8}, 64'd1);
    wait_done8(cyc, bcnt);
    chk("latency_with_ignored", 64'(cyc), 64'd5);
    @(negedge clk);

    // Reset mid-RUN aborts without a done pulse
    start8_t(8'h5A, 8'h3C, 1'b1, 9'h097, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {52'd0, busy8, done8, cout8, sum8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(ndone8), 64'(nstart8));
    start8_t(8'h33, 8'h44, 1'b1, 9'h078, 1'b1);
    wait_done8(cyc, bcnt);
    chk("latency_after_abort", 64'(cyc), 64'd8);
    @(negedge clk);

    // Back-to-back: start held in the DONE cycle
    start8_t(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
    wait_done8(cyc, bcnt);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    q8.push_back(9'h100);
    nstart8++;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_spacing", 64'(cyc), 64'd9);
    @(negedge clk);
    chk("b2b_done_low", {63'd0, done8}, 64'd0);

    // Random adds on both widths in parallel
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          rc = 1'($urandom);
          start8_t(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, 1'b1);
          wait_done8(cyc, bcnt);
        end
      end
      begin
        for (int j = 0; j < 1000; j++) begin
          int c16;
          wa = 16'($urandom);
          wb = 16'($urandom);
          rc = 1'($urandom);
          a16 = wa; b16 = wb; cin16 = rc; start16 = 1'b1;
          q16.push_back({1'b0, wa} + {1'b0, wb} + {16'd0, rc});
          nstart16++;
          @(negedge clk);
          start16 = 1'b0;
          c16 = 0;
          while (!done16 && c16 < 300) begin
            @(negedge clk);
            c16++;
          end
          if (!done16) begin
            total++;
            bad++;
            $display("FAIL done16_timeout: got no done after %0d cycles, expected done", c16);
          end
        end
      end
    join

    repeat (3) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    chk("done_count8", 64'(ndone8), 64'(nstart8));
    chk("done_count16", 64'(ndone16), 64'(nstart16));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
